// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage and its helpers.
package mem_stage_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 10;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // Control bits captured with a memory instruction while it waits on the bus.
    typedef struct packed {
        logic we;
        logic reg_en;
        logic mem_to_reg;
    } mem_ctrl_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Handshake watchdog: counts cycles while enabled and flags the last allowed cycle.
// Only instantiated when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int Limit = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CntWidth = (Limit > 2) ? $clog2(Limit) : 1;

    logic [CntWidth-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CntWidth'(Limit - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores over req/gnt/rvalid and registers WB results.
// Optional handshake watchdog with BUS_ERR_OUT pulse: define MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DataWidth     = DEF_DATA_WIDTH,
    parameter int AddrWidth     = DEF_ADDR_WIDTH,
    parameter int RegAddrWidth  = DEF_REG_ADDR_WIDTH,
    parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    MEM_to_REG_IN,
    input  logic                    MEM_READ_IN,
    input  logic                    MEM_WRITE_IN,
    input  logic                    Reg_EN_IN,
    input  logic [DataWidth-1:0]    ALU_Result_IN,
    input  logic [AddrWidth-1:0]    D_MEM_ADDR_IN,
    input  logic [DataWidth-1:0]    DataIN_MEM_IN,
    input  logic [RegAddrWidth-1:0] WB_REG_IN,
    output logic                    DMEM_REQ,
    output logic                    DMEM_WE,
    output logic [AddrWidth-1:0]    DMEM_ADDR,
    output logic [DataWidth-1:0]    DMEM_WDATA,
    input  logic                    DMEM_GNT,
    input  logic                    DMEM_RVALID,
    input  logic [DataWidth-1:0]    DMEM_RDATA,
    output logic                    PIPE_STALL,
    output logic                    Reg_EN_OUT,
    output logic [RegAddrWidth-1:0] WB_REG_OUT,
    output logic [DataWidth-1:0]    WB_DATA_OUT,
    output logic                    BUS_ERR_OUT
);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("mem_access_stage: TimeoutCycles must be at least 2");
    end

    // Handshake: DMEM_REQ stays high with stable DMEM_WE/ADDR/WDATA until the
    // cycle DMEM_GNT is sampled high; a granted load then waits for DMEM_RVALID,
    // which qualifies DMEM_RDATA. GNT outside REQ and RVALID outside RESP are ignored.

    mem_state_e              state_q, state_d;
    mem_ctrl_t               ctrl_q;
    logic [AddrWidth-1:0]    addr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth-1:0]    alu_q;
    logic [RegAddrWidth-1:0] wb_reg_q;

    logic mem_op;
    logic capture;
    logic pass;
    logic wb_load;
    logic stall;
    logic abort;

    assign mem_op = MEM_READ_IN | MEM_WRITE_IN;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        pass    = 1'b0;
        wb_load = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    capture = 1'b1;
                    stall   = 1'b1;
                    state_d = REQ;
                end else begin
                    pass = 1'b1;
                end
            end
            REQ: begin
                if (DMEM_GNT) begin
                    if (ctrl_q.we) begin
                        state_d = IDLE;
                    end else begin
                        stall   = 1'b1;
                        state_d = RESP;
                    end
                end else if (abort) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            RESP: begin
                if (DMEM_RVALID) begin
                    wb_load = 1'b1;
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_q       <= '0;
            wb_reg_q    <= '0;
            Reg_EN_OUT  <= 1'b0;
            WB_REG_OUT  <= '0;
            WB_DATA_OUT <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ctrl_q.we         <= MEM_WRITE_IN;
                ctrl_q.reg_en     <= Reg_EN_IN;
                ctrl_q.mem_to_reg <= MEM_to_REG_IN;
                addr_q            <= D_MEM_ADDR_IN;
                wdata_q           <= DataIN_MEM_IN;
                alu_q             <= ALU_Result_IN;
                wb_reg_q          <= WB_REG_IN;
            end
            // Stall, store and abort cycles insert a bubble; WB data/dest hold.
            if (pass) begin
                Reg_EN_OUT  <= Reg_EN_IN;
                WB_REG_OUT  <= WB_REG_IN;
                WB_DATA_OUT <= ALU_Result_IN;
            end else if (wb_load) begin
                Reg_EN_OUT  <= ctrl_q.reg_en;
                WB_REG_OUT  <= wb_reg_q;
                WB_DATA_OUT <= ctrl_q.mem_to_reg ? DMEM_RDATA : alu_q;
            end else begin
                Reg_EN_OUT <= 1'b0;
            end
        end
    end

    assign PIPE_STALL = stall;
    assign DMEM_REQ   = (state_q == REQ);
    assign DMEM_WE    = ctrl_q.we;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_WDATA = wdata_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic tmo_expire;

    mem_timeout_ctr #(
        .Limit (TimeoutCycles)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (capture),
        .enable (state_q != IDLE),
        .expire (tmo_expire)
    );

    // A handshake landing on the final cycle completes normally.
    assign abort = tmo_expire &
                   ~(((state_q == REQ) & DMEM_GNT) | ((state_q == RESP) & DMEM_RVALID));

    always_ff @(posedge clock) begin
        if (reset) begin
            BUS_ERR_OUT <= 1'b0;
        end else begin
            BUS_ERR_OUT <= abort;
        end
    end
`else
    assign abort       = 1'b0;
    assign BUS_ERR_OUT = 1'b0;
`endif

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues load/store requests to data memory over a req/gnt/rvalid handshake and stalls the pipeline while a request is outstanding.
- Produces registered write-back data, destination register and enable for the WB stage.

Parameters:
- DataWidth, 32, data/ALU result width
- AddrWidth, 10, data memory word address width
- RegAddrWidth, 5, register file address width
- TimeoutCycles, 16, handshake timeout limit in cycles (used only with the optional feature)

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- MEM_to_REG_IN  in  1  write back memory data instead of ALU result
- MEM_READ_IN  in  1  load
- MEM_WRITE_IN  in  1  store
- Reg_EN_IN  in  1  register write enable
- ALU_Result_IN  in  DataWidth  ALU result
- D_MEM_ADDR_IN  in  AddrWidth  memory word address
- DataIN_MEM_IN  in  DataWidth  store data
- WB_REG_IN  in  RegAddrWidth  destination register
- DMEM_REQ  out  1  request valid
- DMEM_WE  out  1  1 = store, 0 = load
- DMEM_ADDR  out  AddrWidth  request address
- DMEM_WDATA  out  DataWidth  store data
- DMEM_GNT  in  1  request accepted
- DMEM_RVALID  in  1  load data valid
- DMEM_RDATA  in  DataWidth  load data
- PIPE_STALL  out  1  combinational; upstream stages hold while high
- Reg_EN_OUT  out  1  registered WB enable
- WB_REG_OUT  out  RegAddrWidth  registered WB destination
- WB_DATA_OUT  out  DataWidth  registered WB data
- BUS_ERR_OUT  out  1  registered one-cycle timeout pulse

Behaviour:
- One clock domain. Reset is synchronous and active-high. Port names are clock and reset.
- Reset: state IDLE; all registered outputs 0; internal capture registers 0. DMEM_REQ is low from the first cycle after the reset edge.
- Reset mid-operation: the outstanding request is abandoned. A late GNT or RVALID arriving in IDLE is ignored.
- mem_op = MEM_READ_IN | MEM_WRITE_IN. If both are asserted, the operation is a store; MEM_READ_IN is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, no mem_op: next cycle Reg_EN_OUT=Reg_EN_IN, WB_REG_OUT=WB_REG_IN, WB_DATA_OUT=ALU_Result_IN. PIPE_STALL=0. Zero-bubble pass-through.
- IDLE, mem_op: capture addr, wdata, we, Reg_EN, WB_REG, MEM_to_REG, ALU_Result; go to REQ. PIPE_STALL=1; Reg_EN_OUT<=0 (bubble).
- REQ: DMEM_REQ=1, driven from the captured values. PIPE_STALL=1 unless completing.
  - GNT with store: complete; PIPE_STALL=0; Reg_EN_OUT<=0; go to IDLE.
  - GNT with load: go to RESP.
  - RVALID in REQ is ignored.
- RESP: DMEM_REQ=0.
  - On RVALID: complete; PIPE_STALL=0; Reg_EN_OUT<=captured Reg_EN; WB_REG_OUT<=captured WB_REG; WB_DATA_OUT<=DMEM_RDATA if captured MEM_to_REG, else captured ALU_Result; go to IDLE.
  - GNT in RESP is ignored.
- Minimum latency: store 2 cycles (IDLE, REQ with GNT); load 3 cycles (IDLE, REQ, RESP with RVALID).
- Completion cycle: PIPE_STALL=0, so upstream advances. The held input is not re-captured because the FSM is leaving the state. The next instruction is evaluated in IDLE on the following cycle.
- Every non-completing stall cycle writes Reg_EN_OUT<=0. WB_REG_OUT and WB_DATA_OUT hold their previous values.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - When it reaches TimeoutCycles-1 without the awaited GNT/RVALID: abort to IDLE; PIPE_STALL=0 that cycle; Reg_EN_OUT<=0; BUS_ERR_OUT<=1 for exactly one cycle.
  - If the handshake arrives in the same cycle as the timeout, the handshake wins and no error is raised.
- Undefined: the FSM waits indefinitely; BUS_ERR_OUT is tied to 0; no counter logic is present.

Decomposition:
- Shared package mem_stage_pkg: state enum (IDLE, REQ, RESP), a capture-record struct, default width constants.
- One sub-module: mem_timeout_ctr (clear, enable, expire output), instantiated only under MEM_ACCESS_TIMEOUT_EN.

Test Plan:
- Non-mem op, ALU_Result_IN=0x1234, Reg_EN_IN=1, WB_REG_IN=5 -> next cycle WB_DATA_OUT=0x1234, WB_REG_OUT=5, Reg_EN_OUT=1, PIPE_STALL=0 throughout.
- Load, addr 0x3F, MEM_to_REG=1, GNT after 2 cycles, RVALID with 0xDEADBEEF 1 cycle later -> DMEM_REQ/DMEM_ADDR=0x3F held until GNT; PIPE_STALL high 4 cycles; then WB_DATA_OUT=0xDEADBEEF, Reg_EN_OUT=1.
- Store, addr 0x010, data 0xA5A5A5A5, GNT same cycle REQ rises -> DMEM_WE=1, one stall cycle, Reg_EN_OUT stays 0.
- MEM_READ_IN=MEM_WRITE_IN=1 -> DMEM_WE=1; completes as a store with no RVALID wait.
- Reset asserted in RESP -> next cycle IDLE, DMEM_REQ=0, all outputs 0; a later RVALID produces no write-back.
- With MEM_ACCESS_TIMEOUT_EN and TimeoutCycles=16, GNT never asserted -> abort after 16 cycles in REQ; BUS_ERR_OUT high exactly 1 cycle; PIPE_STALL drops; Reg_EN_OUT=0.
